adder_sched: RTL

- Round-robin scheduler that shares one bit-serial adder between NUM_REQ requesters.
- Accepts one WIDTH-bit operand pair per grant and serialises it LSB-first onto the adder's en_i/in1/in2 pins.
- Collects en_o/out bits back into a WIDTH+1-bit sum and returns it on a single tagged response channel.
- Sits between the requester blocks and the shared serial adder.

---
 rtl/adder_sched.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/adder_sched.sv
// Round-robin scheduler sharing one LSB-first bit-serial adder between
// NUM_REQ requesters. Each granted operand pair is streamed onto the adder,
// the returned sum bits are collected by counting add_en_o pulses, and the
// WIDTH+1-bit result comes back on one tagged response channel.
module adder_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH:0]             rsp_sum,
  output logic                       rsp_err,
  output logic                       add_en_i,
  output logic                       add_in1,
  output logic                       add_in2,
  input  logic                       add_en_o,
  input  logic                       add_out,
  output logic                       err_sticky
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, RESP} state_t;

  state_t             state_reg, state_next;
  logic [ID_W-1:0]    ptr_reg;
  logic [ID_W-1:0]    id_reg;
  logic [WIDTH-1:0]   a_sh_reg, b_sh_reg;
  logic [WIDTH:0]     sum_reg;
  logic [CNT_W-1:0]   bitcnt_reg, rxcnt_reg;
  logic [TO_W-1:0]    drain_cnt_reg;
  logic               err_reg;
  logic               err_sticky_reg;

  logic [WIDTH-1:0]   a_arr [NUM_REQ];
  logic [WIDTH-1:0]   b_arr [NUM_REQ];
  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    cand_idx;

  logic in_op, rx_full, capture, stray, rx_done_next, last_bit, drain_expired;

  // Unpack the flat operand buses into per-requester words.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Pick the first valid requester after the round-robin pointer, with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_idx = ID_W'((int'(ptr_reg) + off) % NUM_REQ);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // A pulse is captured only while an operation expects result bits; any
  // other add_en_o is stray and flagged.
  assign in_op         = (state_reg == SEND) || (state_reg == DRAIN);
  assign rx_full       = (rxcnt_reg == CNT_W'(WIDTH + 1));
  assign capture       = in_op && add_en_o && !rx_full;
  assign stray         = add_en_o && !capture;
  // Completion looks at this cycle's capture so a zero-latency adder can go
  // straight to RESP and the response rises at T+WIDTH+2+L.
  assign rx_done_next  = rx_full || (capture && (rxcnt_reg == CNT_W'(WIDTH)));
  assign last_bit      = (bitcnt_reg == CNT_W'(WIDTH));
  assign drain_expired = (drain_cnt_reg == TO_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_found) state_next = SEND;
      SEND:    if (last_bit) state_next = rx_done_next ? RESP : DRAIN;
      DRAIN:   if (rx_done_next || drain_expired) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand shifting, result collection, counters and error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg        <= ID_W'(NUM_REQ - 1);
      id_reg         <= '0;
      a_sh_reg       <= '0;
      b_sh_reg       <= '0;
      sum_reg        <= '0;
      bitcnt_reg     <= '0;
      rxcnt_reg      <= '0;
      drain_cnt_reg  <= '0;
      err_reg        <= 1'b0;
      err_sticky_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && grant_found) begin
        a_sh_reg      <= a_arr[grant_idx];
        b_sh_reg      <= b_arr[grant_idx];
        id_reg        <= grant_idx;
        ptr_reg       <= grant_idx;
        sum_reg       <= '0;
        bitcnt_reg    <= '0;
        rxcnt_reg     <= '0;
        drain_cnt_reg <= '0;
        err_reg       <= 1'b0;
      end
      // Shift in zeros so the extra flush bit drives 0 on both operands.
      if (state_reg == SEND) begin
        a_sh_reg   <= a_sh_reg >> 1;
        b_sh_reg   <= b_sh_reg >> 1;
        bitcnt_reg <= bitcnt_reg + 1'b1;
      end
      if (capture) begin
        sum_reg   <= {add_out, sum_reg[WIDTH:1]};
        rxcnt_reg <= rxcnt_reg + 1'b1;
      end
      if (state_reg == DRAIN) begin
        drain_cnt_reg <= drain_cnt_reg + 1'b1;
        if (!rx_done_next && drain_expired) begin
          err_reg <= 1'b1;
          sum_reg <= '0;
        end
      end
      if (stray) err_sticky_reg <= 1'b1;
    end
  end

  // Output decode from state and held registers.
  always_comb begin
    req_ready = '0;
    if (state_reg == IDLE && grant_found && !rst) req_ready[grant_idx] = 1'b1;
    add_en_i  = (state_reg == SEND);
    add_in1   = (state_reg == SEND) & a_sh_reg[0];
    add_in2   = (state_reg == SEND) & b_sh_reg[0];
    rsp_valid = (state_reg == RESP);
    rsp_id    = rsp_valid ? id_reg : '0;
    rsp_sum   = (rsp_valid && !err_reg) ? sum_reg : '0;
    rsp_err   = rsp_valid & err_reg;
  end

  assign err_sticky = err_sticky_reg;

endmodule
